// File: rtl/user_module_project_id_pkg.sv
// Shared encodings and transition record for the Turing machine rule table.
package user_module_project_id_pkg;

  localparam logic [2:0] ST_A = 3'd0;
  localparam logic [2:0] ST_B = 3'd1;
  localparam logic [2:0] ST_C = 3'd2;
  localparam logic [2:0] ST_D = 3'd3;
  localparam logic [2:0] ST_E = 3'd4;
  localparam logic [2:0] ST_F = 3'd5;
  localparam logic [2:0] ST_G = 3'd6;
  localparam logic [2:0] ST_H = 3'd7;

  localparam logic [2:0] SYM_0 = 3'b000;
  localparam logic [2:0] SYM_1 = 3'b001;
  localparam logic [2:0] SYM_2 = 3'b010;
  localparam logic [2:0] SYM_4 = 3'b100;
  localparam logic [2:0] SYM_5 = 3'b101;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  typedef struct packed {
    logic [2:0] next_state;
    logic [2:0] new_sym;
    logic       dir;
  } trans_t;

  function automatic trans_t mk_trans(logic [2:0] next_state, logic [2:0] new_sym, logic dir);
    trans_t t;
    t.next_state = next_state;
    t.new_sym    = new_sym;
    t.dir        = dir;
    return t;
  endfunction

endpackage

// File: rtl/utm_rule_rom.sv
// Combinational rule table: (state, symbol) -> {next_state, new_sym, dir}.
module utm_rule_rom
  import user_module_project_id_pkg::*;
(
  input  logic [2:0] state,
  input  logic [2:0] sym,
  output trans_t     rule
);

  always_comb begin
    rule = mk_trans(state, sym, DIR_L);
    case ({state, sym})
      {ST_A, SYM_0}: rule = mk_trans(ST_B, SYM_1, DIR_R);
      {ST_A, SYM_1}: rule = mk_trans(ST_A, SYM_2, DIR_R);
      {ST_A, SYM_2}: rule = mk_trans(ST_C, SYM_0, DIR_L);
      {ST_A, SYM_4}: rule = mk_trans(ST_A, SYM_5, DIR_R);
      {ST_A, SYM_5}: rule = mk_trans(ST_D, SYM_4, DIR_L);
      {ST_B, SYM_0}: rule = mk_trans(ST_C, SYM_2, DIR_L);
      {ST_B, SYM_1}: rule = mk_trans(ST_B, SYM_1, DIR_R);
      {ST_B, SYM_2}: rule = mk_trans(ST_A, SYM_4, DIR_R);
      {ST_B, SYM_4}: rule = mk_trans(ST_E, SYM_0, DIR_L);
      {ST_B, SYM_5}: rule = mk_trans(ST_B, SYM_5, DIR_R);
      {ST_C, SYM_0}: rule = mk_trans(ST_A, SYM_1, DIR_L);
      {ST_C, SYM_1}: rule = mk_trans(ST_D, SYM_0, DIR_R);
      {ST_C, SYM_2}: rule = mk_trans(ST_C, SYM_2, DIR_L);
      {ST_C, SYM_4}: rule = mk_trans(ST_F, SYM_5, DIR_R);
      {ST_C, SYM_5}: rule = mk_trans(ST_C, SYM_1, DIR_L);
      {ST_D, SYM_0}: rule = mk_trans(ST_E, SYM_4, DIR_R);
      {ST_D, SYM_1}: rule = mk_trans(ST_D, SYM_1, DIR_L);
      {ST_D, SYM_2}: rule = mk_trans(ST_B, SYM_5, DIR_R);
      {ST_D, SYM_4}: rule = mk_trans(ST_D, SYM_4, DIR_R);
      {ST_D, SYM_5}: rule = mk_trans(ST_G, SYM_0, DIR_L);
      {ST_E, SYM_0}: rule = mk_trans(ST_F, SYM_1, DIR_R);
      {ST_E, SYM_1}: rule = mk_trans(ST_E, SYM_2, DIR_L);
      {ST_E, SYM_2}: rule = mk_trans(ST_D, SYM_0, DIR_R);
      {ST_E, SYM_4}: rule = mk_trans(ST_A, SYM_4, DIR_L);
      {ST_E, SYM_5}: rule = mk_trans(ST_E, SYM_5, DIR_R);
      {ST_F, SYM_0}: rule = mk_trans(ST_G, SYM_5, DIR_L);
      {ST_F, SYM_1}: rule = mk_trans(ST_F, SYM_1, DIR_R);
      {ST_F, SYM_2}: rule = mk_trans(ST_E, SYM_2, DIR_R);
      {ST_F, SYM_4}: rule = mk_trans(ST_C, SYM_0, DIR_L);
      {ST_F, SYM_5}: rule = mk_trans(ST_F, SYM_4, DIR_R);
      {ST_G, SYM_0}: rule = mk_trans(ST_H, SYM_0, DIR_R);
      {ST_G, SYM_1}: rule = mk_trans(ST_G, SYM_2, DIR_L);
      {ST_G, SYM_2}: rule = mk_trans(ST_F, SYM_1, DIR_R);
      {ST_G, SYM_4}: rule = mk_trans(ST_B, SYM_4, DIR_L);
      {ST_G, SYM_5}: rule = mk_trans(ST_G, SYM_5, DIR_L);
      // Halt state H and illegal symbols both reduce to hold: same state, echo symbol, left.
      default:       rule = mk_trans(state, sym, DIR_L);
    endcase
  end

endmodule

// File: rtl/user_module_project_id.sv
// 8-in/8-out wrapper around the rule table, plus the sticky registered halt flag.
module user_module_project_id
  import user_module_project_id_pkg::*;
(
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic       clk;
  logic       rst_n;
  logic [2:0] state_in;
  logic [2:0] sym_in;
  trans_t     rule;
  logic       halted_q;

  assign clk      = io_in[0];
  assign state_in = io_in[3:1];
  assign sym_in   = io_in[6:4];
  assign rst_n    = io_in[7];

  utm_rule_rom u_rule_rom (
    .state (state_in),
    .sym   (sym_in),
    .rule  (rule)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_q | (state_in == ST_H);
    end
  end

  assign io_out = {rule.next_state, rule.new_sym, rule.dir, halted_q};

endmodule

// File: tb/tb_user_module_project_id.sv
// Self-checking bench: string-encoded rule table model plus sticky halt model.
module tb_user_module_project_id;

  logic [7:0] io_in;
  logic [7:0] io_out;

  int checks = 0;
  int errors = 0;
  bit halted_m = 1'b0;
  string rules [7];

  user_module_project_id dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  // Expected io_out[7:1] from the textual rule table.
  function automatic logic [6:0] model_comb(input int s, input int c);
    string e;
    int idx, ns, ws, dr;
    logic [2:0] s3, c3;
    s3 = s[2:0];
    c3 = c[2:0];
    if (c == 3 || c == 6 || c == 7) return {s3, c3, 1'b0};
    if (s == 7) return {3'd7, c3, 1'b0};
    idx = (c < 3) ? c : c - 1;
    e = rules[s].substr(idx * 4, idx * 4 + 2);
    ns = int'(e[0]) - 65;
    ws = int'(e[1]) - 48;
    dr = (int'(e[2]) == 82) ? 1 : 0;
    return {ns[2:0], ws[2:0], dr[0]};
  endfunction

  task automatic drive(input int s, input int c, input bit rst_n);
    logic [2:0] s3, c3;
    s3 = s[2:0];
    c3 = c[2:0];
    io_in = {rst_n, c3, s3, 1'b0};
    if (!rst_n) halted_m = 1'b0;
    #1;
  endtask

  task automatic pulse_clk();
    io_in[0] = 1'b1;
    if (io_in[7] && io_in[3:1] == 3'd7) halted_m = 1'b1;
    #5;
    io_in[0] = 1'b0;
    #5;
  endtask

  task automatic test_reset();
    drive(0, 0, 1'b0);
    checks++;
    if (io_out !== 8'h26) begin
      errors++;
      $display("FAIL reset_a0: got %h expected 26", io_out);
    end
    drive(2, 4, 1'b0);
    checks++;
    if (io_out !== 8'hB6) begin
      errors++;
      $display("FAIL reset_c4: got %h expected b6", io_out);
    end
    drive(6, 0, 1'b0);
    checks++;
    if (io_out !== 8'hE2) begin
      errors++;
      $display("FAIL reset_g0: got %h expected e2", io_out);
    end
  endtask

  task automatic test_illegal();
    drive(0, 3, 1'b0);
    checks++;
    if (io_out !== 8'h0C) begin
      errors++;
      $display("FAIL illegal_a3: got %h expected 0c", io_out);
    end
  endtask

  task automatic test_halt_flag();
    drive(7, 0, 1'b1);
    checks++;
    if (io_out !== 8'hE0) begin
      errors++;
      $display("FAIL halt_pre_clk: got %h expected e0", io_out);
    end
    pulse_clk();
    checks++;
    if (io_out !== 8'hE1) begin
      errors++;
      $display("FAIL halt_set: got %h expected e1", io_out);
    end
    drive(0, 0, 1'b1);
    pulse_clk();
    checks++;
    if (io_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL halt_sticky: got %b expected 1", io_out[0]);
    end
    io_in[7] = 1'b0;
    halted_m = 1'b0;
    #1;
    checks++;
    if (io_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL halt_async_clear: got %b expected 0", io_out[0]);
    end
  endtask

  // Reset falling together with a clock rise in state H: reset must win.
  task automatic test_reset_with_clk();
    drive(7, 1, 1'b1);
    io_in = 8'h1F;
    halted_m = 1'b0;
    #5;
    io_in[0] = 1'b0;
    #1;
    checks++;
    if (io_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_with_clk: got %b expected 0", io_out[0]);
    end
  endtask

  task automatic test_sweep();
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 8; c++) begin
        drive(s, c, 1'b0);
        checks++;
        if (io_out !== {model_comb(s, c), 1'b0}) begin
          errors++;
          $display("FAIL sweep s=%0d c=%0d: got %h expected %h", s, c, io_out,
                   {model_comb(s, c), 1'b0});
        end
      end
    end
  endtask

  task automatic test_random();
    int s, c, act;
    bit rst_n;
    for (int i = 0; i < 400; i++) begin
      s = int'($urandom_range(0, 7));
      c = int'($urandom_range(0, 7));
      act = int'($urandom_range(0, 9));
      rst_n = (act != 0);
      drive(s, c, rst_n);
      if (act >= 5) pulse_clk();
      checks++;
      if (io_out !== {model_comb(s, c), halted_m}) begin
        errors++;
        $display("FAIL random i=%0d s=%0d c=%0d rst_n=%0b: got %h expected %h", i, s, c, rst_n,
                 io_out, {model_comb(s, c), halted_m});
      end
    end
  endtask

  initial begin
    rules[0] = "B1R,A2R,C0L,A5R,D4L";
    rules[1] = "C2L,B1R,A4R,E0L,B5R";
    rules[2] = "A1L,D0R,C2L,F5R,C1L";
    rules[3] = "E4R,D1L,B5R,D4R,G0L";
    rules[4] = "F1R,E2L,D0R,A4L,E5R";
    rules[5] = "G5L,F1R,E2R,C0L,F4R";
    rules[6] = "H0R,G2L,F1R,B4L,G5L";
    io_in = 8'h00;
    #2;
    checks++;
    if (io_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_halted: got %b expected 0", io_out[0]);
    end
    test_reset();
    test_illegal();
    test_halt_flag();
    test_reset_with_clk();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
